// File: rtl/board_manager.sv
// Tic-tac-toe board manager: debounces the player's key, owns the X/O occupancy and enforces turn order.
// Optional macro CPU_STARTS_EN: the bot places the first O after reset, triggered by a single user_moved pulse.
module board_manager #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] square_sel,
    input  logic       enter_n,
    input  logic [3:0] cpu_move,
    input  logic       cpu_move_valid,
    input  logic       game_over,
    output logic [8:0] x_spots,
    output logic [8:0] o_spots,
    output logic       user_moved,
    output logic       cpu_turn,
    output logic       illegal_move,
    output logic [3:0] move_count,
    output logic       locked
);

    typedef enum logic [1:0] {WAIT_USER, VALIDATE, CPU_TURN, LOCKED} state_t;

`ifdef CPU_STARTS_EN
    localparam state_t StartState = CPU_TURN;
    localparam logic   StartCpu   = 1'b1;
`else
    localparam state_t StartState = WAIT_USER;
    localparam logic   StartCpu   = 1'b0;
`endif

    logic             syncMeta;
    logic             syncLevel;
    logic             keyLevel;
    logic             pressEvent;
    logic [CNT_W-1:0] stableCount;
    logic [3:0]       squareReg;
    state_t           state;
    logic [8:0]       occupied;
    logic [8:0]       userMask;
    logic [8:0]       cpuMask;
    logic             userLegal;
    logic             cpuLegal;
`ifdef CPU_STARTS_EN
    logic             startPending;
`endif

    // The counter holds samples-seen minus one, so the level flips on the DEBOUNCE_CYCLES-th differing sample.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            syncMeta    <= 1'b1;
            syncLevel   <= 1'b1;
            keyLevel    <= 1'b1;
            stableCount <= '0;
            pressEvent  <= 1'b0;
            squareReg   <= '0;
        end else begin
            syncMeta   <= enter_n;
            syncLevel  <= syncMeta;
            pressEvent <= 1'b0;
            if (syncLevel == keyLevel) begin
                stableCount <= '0;
            end else if (stableCount == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                keyLevel    <= syncLevel;
                stableCount <= '0;
                if (!syncLevel) begin
                    pressEvent <= 1'b1;
                    squareReg  <= square_sel;
                end
            end else begin
                stableCount <= stableCount + 1'b1;
            end
        end
    end

    assign occupied  = x_spots | o_spots;
    assign userMask  = 9'd1 << squareReg;
    assign cpuMask   = 9'd1 << cpu_move;
    assign userLegal = (squareReg < 4'd9) && ((occupied & userMask) == '0);
    assign cpuLegal  = (cpu_move < 4'd9) && ((occupied & cpuMask) == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= StartState;
            x_spots      <= '0;
            o_spots      <= '0;
            user_moved   <= 1'b0;
            cpu_turn     <= StartCpu;
            illegal_move <= 1'b0;
            move_count   <= '0;
            locked       <= 1'b0;
`ifdef CPU_STARTS_EN
            startPending <= 1'b1;
`endif
        end else begin
            user_moved   <= 1'b0;
            illegal_move <= 1'b0;
`ifdef CPU_STARTS_EN
            if (startPending) begin
                user_moved   <= 1'b1;
                startPending <= 1'b0;
            end
`endif
            // Game end wins over any commit pending in the same cycle.
            if (state != LOCKED && (game_over || move_count == 4'd9)) begin
                state    <= LOCKED;
                cpu_turn <= 1'b0;
                locked   <= 1'b1;
            end else begin
                case (state)
                    WAIT_USER: begin
                        if (pressEvent) state <= VALIDATE;
                    end
                    VALIDATE: begin
                        if (userLegal) begin
                            x_spots    <= x_spots | userMask;
                            move_count <= move_count + 1'b1;
                            user_moved <= 1'b1;
                            cpu_turn   <= 1'b1;
                            state      <= CPU_TURN;
                        end else begin
                            illegal_move <= 1'b1;
                            state        <= WAIT_USER;
                        end
                    end
                    CPU_TURN: begin
                        if (cpu_move_valid) begin
                            if (cpuLegal) begin
                                o_spots    <= o_spots | cpuMask;
                                move_count <= move_count + 1'b1;
                                cpu_turn   <= 1'b0;
                                state      <= WAIT_USER;
                            end else begin
                                illegal_move <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_board_manager.sv
// Self-checking bench for board_manager: directed vector table, corner sequences and randomized games
// against a rule-level board model.
module tb_board_manager;

    localparam int DEB = 16;
`ifdef CPU_STARTS_EN
    localparam bit CPU_FIRST = 1'b1;
`else
    localparam bit CPU_FIRST = 1'b0;
`endif
    localparam logic [8:0] BASE_O  = CPU_FIRST ? 9'h040 : 9'h000;
    localparam int         BASE_MC = CPU_FIRST ? 1 : 0;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] square_sel = '0;
    logic       enter_n = 1'b1;
    logic [3:0] cpu_move = '0;
    logic       cpu_move_valid = 1'b0;
    logic       game_over = 1'b0;
    logic [8:0] x_spots;
    logic [8:0] o_spots;
    logic       user_moved;
    logic       cpu_turn;
    logic       illegal_move;
    logic [3:0] move_count;
    logic       locked;

    board_manager #(.DEBOUNCE_CYCLES(DEB), .CNT_W(20)) dut (
        .clock(clock), .reset(reset), .square_sel(square_sel), .enter_n(enter_n),
        .cpu_move(cpu_move), .cpu_move_valid(cpu_move_valid), .game_over(game_over),
        .x_spots(x_spots), .o_spots(o_spots), .user_moved(user_moved), .cpu_turn(cpu_turn),
        .illegal_move(illegal_move), .move_count(move_count), .locked(locked)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int umTotal = 0;
    int illTotal = 0;

    always @(negedge clock) begin
        if (!reset) begin
            if (user_moved === 1'b1) umTotal++;
            if (illegal_move === 1'b1) illTotal++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Reference model: board as two sets of squares, whose turn it is (0 player, 1 cpu, 2 over).
    logic [8:0] mX, mO;
    int mMoves, mTurn, expUm, expIll;

    function automatic bit isFree(input int sq);
        if (sq < 0 || sq > 8) return 1'b0;
        return !(mX[sq] || mO[sq]);
    endfunction

    function automatic void modelReset();
        mX = '0; mO = '0; mMoves = 0;
        mTurn = CPU_FIRST ? 1 : 0;
    endfunction

    function automatic void modelApply(input int kind, input int sq);
        expUm = 0; expIll = 0;
        if (mTurn == 2) return;
        if (kind == 3) begin
            mTurn = 2;
        end else if (kind == 0 && mTurn == 0) begin
            if (isFree(sq)) begin
                mX[sq] = 1'b1; mMoves++; mTurn = 1; expUm = 1;
            end else expIll = 1;
        end else if (kind == 1 && mTurn == 1) begin
            if (isFree(sq)) begin
                mO[sq] = 1'b1; mMoves++; mTurn = 0;
            end else expIll = 1;
        end
        if (mMoves == 9) mTurn = 2;
    endfunction

    // kind: 0 press, 1 cpu move, 2 short glitch, 3 game_over pulse
    task automatic runAction(input int kind, input int sq, output int um, output int ill);
        int um0, ill0;
        um0 = umTotal; ill0 = illTotal;
        case (kind)
            0, 2: begin
                square_sel = 4'(sq);
                enter_n = 1'b0;
                tick(kind == 0 ? DEB + 8 : 10);
                enter_n = 1'b1;
                tick(DEB + 8);
            end
            1: begin
                cpu_move = 4'(sq);
                cpu_move_valid = 1'b1;
                tick(1);
                cpu_move_valid = 1'b0;
                tick(3);
            end
            default: begin
                game_over = 1'b1;
                tick(1);
                game_over = 1'b0;
                tick(3);
            end
        endcase
        um = umTotal - um0;
        ill = illTotal - ill0;
    endtask

    task automatic startGame();
        int um, ill;
        reset = 1'b1; enter_n = 1'b1; cpu_move_valid = 1'b0; game_over = 1'b0;
        square_sel = '0; cpu_move = '0;
        tick(2);
        reset = 1'b0;
        tick(3);
        modelReset();
        if (CPU_FIRST) begin
            modelApply(1, 6);
            runAction(1, 6, um, ill);
        end
    endtask

    typedef struct {
        int kind; int sq; logic [8:0] x; logic [8:0] o; int mc; logic ct; int um; int ill;
    } vec_t;
    vec_t vecs[12];

    initial begin
        int um, ill, um0;
        vecs[0]  = '{2,  3, 9'h000, 9'h000, 0, 1'b0, 0, 0};
        vecs[1]  = '{0,  4, 9'h010, 9'h000, 1, 1'b1, 1, 0};
        vecs[2]  = '{1,  4, 9'h010, 9'h000, 1, 1'b1, 0, 1};
        vecs[3]  = '{1,  0, 9'h010, 9'h001, 2, 1'b0, 0, 0};
        vecs[4]  = '{0,  9, 9'h010, 9'h001, 2, 1'b0, 0, 1};
        vecs[5]  = '{0,  4, 9'h010, 9'h001, 2, 1'b0, 0, 1};
        vecs[6]  = '{0,  0, 9'h010, 9'h001, 2, 1'b0, 0, 1};
        vecs[7]  = '{0,  8, 9'h110, 9'h001, 3, 1'b1, 1, 0};
        vecs[8]  = '{0,  2, 9'h110, 9'h001, 3, 1'b1, 0, 0};
        vecs[9]  = '{1, 15, 9'h110, 9'h001, 3, 1'b1, 0, 1};
        vecs[10] = '{1,  2, 9'h110, 9'h005, 4, 1'b0, 0, 0};
        vecs[11] = '{0, 15, 9'h110, 9'h005, 4, 1'b0, 0, 1};

        // Reset state
        tick(2);
        check("rst_x", x_spots, 9'h000);
        check("rst_o", o_spots, 9'h000);
        check("rst_mc", move_count, 4'd0);
        check("rst_cpu_turn", cpu_turn, CPU_FIRST);
        check("rst_locked", locked, 1'b0);
        check("rst_user_moved", user_moved, 1'b0);
        check("rst_illegal", illegal_move, 1'b0);

        // Directed vector table
        startGame();
        for (int i = 0; i < 12; i++) begin
            runAction(vecs[i].kind, vecs[i].sq, um, ill);
            check($sformatf("vec%0d_x", i), x_spots, vecs[i].x);
            check($sformatf("vec%0d_o", i), o_spots, vecs[i].o | BASE_O);
            check($sformatf("vec%0d_mc", i), move_count, vecs[i].mc + BASE_MC);
            check($sformatf("vec%0d_cpu_turn", i), cpu_turn, vecs[i].ct);
            check($sformatf("vec%0d_user_moved", i), um, vecs[i].um);
            check($sformatf("vec%0d_illegal", i), ill, vecs[i].ill);
        end

        // Press latency: commit lands DEB+4 edges after the first low sample
        startGame();
        square_sel = 4'd4;
        enter_n = 1'b0;
        for (int k = 1; k <= DEB + 5; k++) begin
            tick(1);
            if (k == DEB + 3) begin
                check("lat_x_before", x_spots, 9'h000);
                check("lat_um_before", user_moved, 1'b0);
            end
            if (k == DEB + 4) begin
                check("lat_x_at", x_spots, 9'h010);
                check("lat_um_at", user_moved, 1'b1);
            end
            if (k == DEB + 5) begin
                check("lat_um_after", user_moved, 1'b0);
                check("lat_cpu_turn", cpu_turn, 1'b1);
                check("lat_mc", move_count, BASE_MC + 1);
            end
        end
        enter_n = 1'b1;
        tick(DEB + 8);
        cpu_move = 4'd0;
        cpu_move_valid = 1'b1;
        tick(1);
        cpu_move_valid = 1'b0;
        check("cpu_lat_o", o_spots, BASE_O | 9'h001);
        check("cpu_lat_cpu_turn", cpu_turn, 1'b0);
        check("cpu_lat_mc", move_count, BASE_MC + 2);

        // game_over together with a cpu move: lock wins, move discarded
        startGame();
        runAction(0, 0, um, ill);
        cpu_move = 4'd4;
        cpu_move_valid = 1'b1;
        game_over = 1'b1;
        tick(1);
        cpu_move_valid = 1'b0;
        game_over = 1'b0;
        tick(1);
        check("go_locked", locked, 1'b1);
        check("go_o", o_spots, BASE_O);
        check("go_cpu_turn", cpu_turn, 1'b0);
        runAction(0, 5, um, ill);
        check("go_press_x", x_spots, 9'h001);
        check("go_press_um", um, 0);
        runAction(1, 5, um, ill);
        check("go_cpu_o", o_spots, BASE_O);
        check("go_cpu_ill", ill, 0);
        check("go_mc", move_count, BASE_MC + 1);

        // Asynchronous reset in the middle of a debounce
        startGame();
        runAction(0, 0, um, ill);
        runAction(1, 4, um, ill);
        runAction(0, 8, um, ill);
        check("mid_x", x_spots, 9'h101);
        enter_n = 1'b0;
        tick(8);
        #3;
        reset = 1'b1;
        #1;
        check("arst_x", x_spots, 9'h000);
        check("arst_o", o_spots, 9'h000);
        check("arst_mc", move_count, 4'd0);
        check("arst_cpu_turn", cpu_turn, CPU_FIRST);
        check("arst_locked", locked, 1'b0);
        check("arst_um", user_moved, 1'b0);
        enter_n = 1'b1;
        tick(2);
        um0 = umTotal;
        reset = 1'b0;
        tick(DEB + 8);
        check("release_um_pulses", umTotal - um0, CPU_FIRST ? 1 : 0);
        check("release_cpu_turn", cpu_turn, CPU_FIRST);
        check("release_x", x_spots, 9'h000);

        // Randomized games against the model
        for (int g = 0; g < 6; g++) begin
            startGame();
            for (int a = 0; a < 30; a++) begin
                int r, kind, sq;
                r = int'($urandom_range(0, 99));
                if (r < 50) begin
                    kind = 0;
                    sq = int'($urandom_range(0, 10));
                end else if (r < 97) begin
                    kind = 1;
                    if ($urandom_range(0, 9) < 7) begin
                        int base;
                        base = int'($urandom_range(0, 8));
                        sq = base;
                        for (int j = 0; j < 9; j++) begin
                            if (isFree((base + j) % 9)) begin
                                sq = (base + j) % 9;
                                break;
                            end
                        end
                    end else sq = int'($urandom_range(0, 9));
                end else begin
                    kind = 3;
                    sq = 0;
                end
                modelApply(kind, sq);
                runAction(kind, sq, um, ill);
                check($sformatf("g%0d_a%0d_x", g, a), x_spots, mX);
                check($sformatf("g%0d_a%0d_o", g, a), o_spots, mO);
                check($sformatf("g%0d_a%0d_mc", g, a), move_count, mMoves);
                check($sformatf("g%0d_a%0d_cpu_turn", g, a), cpu_turn, mTurn == 1);
                check($sformatf("g%0d_a%0d_locked", g, a), locked, mTurn == 2);
                check($sformatf("g%0d_a%0d_um", g, a), um, expUm);
                check($sformatf("g%0d_a%0d_ill", g, a), ill, expIll);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
